// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU through valid/ready handshakes.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to requester 0.

module alu #(
    parameter int width = 64
) (
    input  logic [2:0]       op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] out,
    output logic             negative,
    output logic             zero,
    output logic             overflow
);

    // Overflow is the two's-complement signed overflow of ADD/SUB; logic ops never overflow.
    always_comb begin
        out      = '0;
        overflow = 1'b0;
        case (op)
            3'b010: begin
                out      = a + b;
                overflow = (a[width-1] == b[width-1]) && (out[width-1] != a[width-1]);
            end
            3'b011: begin
                out      = a - b;
                overflow = (a[width-1] != b[width-1]) && (out[width-1] != a[width-1]);
            end
            3'b100:  out = a & b;
            3'b101:  out = a | b;
            3'b110:  out = ~(a | b);
            3'b111:  out = a ^ b;
            default: out = '0;
        endcase
        negative = out[width-1];
        zero     = (out == '0);
    end

endmodule

module alu_arbiter #(
    parameter int width = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [width-1:0] req_a0,
    input  logic [width-1:0] req_b0,
    input  logic [2:0]       req_op0,
    input  logic [width-1:0] req_a1,
    input  logic [width-1:0] req_b1,
    input  logic [2:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [width-1:0] rsp_out,
    output logic             rsp_negative,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [width-1:0]   lat_a;
    logic [width-1:0]   lat_b;
    logic [2:0]         lat_op;
    logic               owner;
    logic               last_grant;
    logic               grant;
    logic [width-1:0]   alu_out;
    logic               alu_negative;
    logic               alu_zero;
    logic               alu_overflow;

    alu #(.width(width)) u_alu (
        .op       (lat_op),
        .a        (lat_a),
        .b        (lat_b),
        .out      (alu_out),
        .negative (alu_negative),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

    // Grant selection: a lone requester always wins; ties depend on the build.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = last_grant & 1'b0;
`endif
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !reset && req_valid[grant])
            req_ready = grant ? 2'b10 : 2'b01;
    end

    assign busy = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid[grant]) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready[owner]) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset in EXEC/RESP simply discards the in-flight op; no response is produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_a        <= '0;
            lat_b        <= '0;
            lat_op       <= '0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            rsp_valid    <= 2'b00;
            rsp_out      <= '0;
            rsp_negative <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req_valid[grant]) begin
                        lat_a      <= grant ? req_a1 : req_a0;
                        lat_b      <= grant ? req_b1 : req_b0;
                        lat_op     <= grant ? req_op1 : req_op0;
                        owner      <= grant;
                        last_grant <= grant;
                    end
                end
                EXEC: begin
                    rsp_out      <= alu_out;
                    rsp_negative <= alu_negative;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow;
                    rsp_valid    <= owner ? 2'b10 : 2'b01;
                end
                RESP: begin
                    if (rsp_ready[owner])
                        rsp_valid <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 64-bit `alu` instance between two requesters using a valid/ready handshake on both the request and the response side. The block arbitrates between the requesters, latches the winner's operands and opcode, and runs the shared ALU for one cycle. It registers the result and flags and holds them until the owning requester accepts them. It sits between the decode/issue logic (requester 0) and the auxiliary address/compare logic (requester 1).

## Interface
- `width`, 64: operand/result width, passed to the internal `alu` instance.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 2: bit i = requester i presents an op.
- `req_ready` output 2: bit i = arbiter accepts requester i this cycle.
- `req_a0`, `req_b0` input `width`: requester 0 operands.
- `req_op0` input 3: requester 0 opcode (010 ADD, 011 SUB, 100 AND, 101 OR, 110 NOR, 111 XOR).
- `req_a1`, `req_b1`, `req_op1`: requester 1 operands and opcode, same widths.
- `rsp_valid` output 2: bit i = result for requester i is held on the response bus.
- `rsp_ready` input 2: bit i = requester i consumes the response.
- `rsp_out` output `width`: registered ALU result. The bus is shared; at most one `rsp_valid` bit is set at a time.
- `rsp_negative`, `rsp_zero`, `rsp_overflow` output 1 each: registered ALU flags.
- `busy` output 1: high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. State encoding is free.
- IDLE:
  - The arbiter picks grant `g` among the set `req_valid` bits.
  - `req_ready[g]` is high combinationally. The other `req_ready` bit is 0.
  - On the edge where `req_valid[g] && req_ready[g]`: latch `a`, `b`, `op` and owner `g`; update `last_grant` to `g`; go to EXEC.
  - With no `req_valid` bit set, stay in IDLE.
- EXEC:
  - The latched operands drive the `alu` instance.
  - On the edge, capture `out`, `negative`, `zero`, `overflow` into the response registers.
  - Set `rsp_valid[g]` and go to RESP.
- RESP:
  - `rsp_*` outputs hold stable.
  - On the edge where `rsp_valid[g] && rsp_ready[g]`: clear `rsp_valid` and go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- `req_ready` is 0 in EXEC and RESP. There is no pipelining and at most one op is in flight.
- Opcodes 000/001 are forwarded unchanged. `rsp_out` and the flags for these codes are unspecified, but the handshake completes normally.
- Arithmetic is modulo 2^`width`. Flags are exactly those produced by `alu` for the latched inputs.

## Timing
- Reset values:
  - `req_ready` = 0 while `reset` is high.
  - `rsp_valid` = 2'b00.
  - `rsp_out` = 0.
  - All flags 0.
  - `busy` = 0.
  - state = IDLE.
  - `last_grant` = 1, so requester 0 wins the first tie.
- Reset asserted in EXEC or RESP drops the in-flight op with no response. The next cycle after `reset` deasserts is IDLE.
- Latency: request accepted at edge E0, then `rsp_valid` is high after edge E1. With `rsp_ready` held high, the response completes at E2. The next accept is possible at E3, so the minimum is 3 cycles per op.
- Request-side rules:
  - A requester may drop `req_valid` before it is accepted; nothing is latched.
  - Operand changes after acceptance have no effect.
- Simultaneous `req_valid` bits in IDLE: resolved per Configuration.
- A response stall of any length holds all `rsp_*` outputs and `busy`.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, grant goes to `~last_grant`.
  - A single valid requester always wins.
- Not defined:
  - Fixed priority: requester 0 wins every tie.
  - `last_grant` is still maintained but does not affect grant.

## Test plan
- Basic op: after reset, requester 0 sends ADD a=1, b=2 → `req_ready[0]`=1 that cycle; `rsp_valid`=01 one edge later; `rsp_out`=3; n/z/o=000; `busy` high for 2 cycles.
- Tie: both requesters valid in the same cycle; req0 SUB 3-2, req1 SUB 1-2.
  - First response: `rsp_valid`=01, out=1.
  - Second response: `rsp_valid`=10, out=0xFFFFFFFFFFFFFFFF, n/z/o=100.
- Sustained contention: both `req_valid` held high for 6 ops.
  - With `ALU_ARB_ROUND_ROBIN_EN`: grants go 0,1,0,1,0,1.
  - Without it: all grants go to 0.
- Backpressure: XOR 0xdeadbeefdeadbeef with itself, `rsp_ready` low for 5 cycles → `rsp_out`=0, zero=1, both held stable; `req_ready`=00 throughout; completes on the first cycle `rsp_ready` is high.
- Overflow: ADD 0x7FFFFFFFFFFFFFFF + 1 → out=0x8000000000000000, n/o=1/1, zero=0.
- Reset mid-op: assert `reset` in RESP → next cycle `rsp_valid`=00, `rsp_out`=0, `busy`=0. The following tie is granted to requester 0.
